// File: rtl/data_memory_responder_if.sv
// data_memory_responder_if: request/response bus between a requester and the data memory responder.
interface data_memory_responder_if;
    logic        request_valid;
    logic        request_ready;
    logic        memory_write;
    logic [31:0] address;
    logic [31:0] write_data;
    logic        response_valid;
    logic [31:0] read_data;
    logic        address_error;
    modport master (
        output request_valid, memory_write, address, write_data,
        input  request_ready, response_valid, read_data, address_error
    );
    modport slave (
        input  request_valid, memory_write, address, write_data,
        output request_ready, response_valid, read_data, address_error
    );
endinterface

// File: rtl/data_memory_responder.sv
// data_memory_responder: word-addressed data memory answering each request after a fixed latency.
module data_memory_responder #(
    parameter int DEPTH_WORDS = 64,
    parameter int LATENCY     = 2
) (
    input logic                     clock,
    input logic                     reset,
    data_memory_responder_if.slave  bus
);
    localparam int AW = $clog2(DEPTH_WORDS);
    typedef enum logic [1:0] {IDLE, WAIT, RESPOND} state_t;
    state_t          state_q, state_d;
    logic [3:0]      count_q, count_d;
    logic            write_q, write_d;
    logic            err_q, err_d;
    logic [AW-1:0]   index_q, index_d;
    logic [31:0]     mem [DEPTH_WORDS];
    logic            accept;
    logic            req_err;
    logic            mem_we;
    always_comb begin
        accept  = bus.request_valid && state_q == IDLE && !reset;
        req_err = (bus.address[1:0] != 2'b00) || (bus.address[31:AW+2] != '0);
        mem_we  = accept && bus.memory_write && !req_err;
        state_d = state_q;
        count_d = count_q;
        write_d = write_q;
        err_d   = err_q;
        index_d = index_q;
        if (accept) begin
            state_d = LATENCY == 1 ? RESPOND : WAIT;
            count_d = 4'(LATENCY - 1);
            write_d = bus.memory_write;
            err_d   = req_err;
            index_d = bus.address[AW+1:2];
        end else if (state_q == WAIT) begin
            count_d = count_q - 4'd1;
            state_d = count_q == 4'd1 ? RESPOND : WAIT;
        end else if (state_q == RESPOND) begin
            state_d = IDLE;
        end
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            index_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            write_q <= write_d;
            err_q   <= err_d;
            index_q <= index_d;
        end
    end
    // Memory is never reset; stores commit on the accept edge so a following load sees them.
    always_ff @(posedge clock) begin
        if (mem_we) mem[bus.address[AW+1:2]] <= bus.write_data;
    end
    assign bus.request_ready  = state_q == IDLE;
    assign bus.response_valid = state_q == RESPOND;
    assign bus.read_data      = (state_q == RESPOND && !write_q && !err_q) ? mem[index_q] : '0;
    assign bus.address_error  = state_q == RESPOND && err_q;
endmodule
